// File: rtl/z80_bus_pkg.sv
// Shared encodings for the Z80 bus master and the command-line parser that drives it.
package z80_bus_pkg;

  typedef enum logic [1:0] {
    OP_HALT    = 2'd0,
    OP_RELEASE = 2'd1,
    OP_READ    = 2'd2,
    OP_WRITE   = 2'd3
  } cmd_op_e;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_REQ      = 3'd1,
    ST_WAIT_ACK = 3'd2,
    ST_OWNED    = 3'd3,
    ST_SETUP    = 3'd4,
    ST_STROBE   = 3'd5,
    ST_HOLD     = 3'd6,
    ST_REL_WAIT = 3'd7
  } bus_state_e;

  // Larger of two integers, used to size the shared phase/ack timer.
  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser; resets to 1 so an idle (high) bus acknowledge is seen after reset.
module sync2 (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  // Shift the asynchronous input through two flops before anyone looks at it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/z80_bus_master.sv
// Z80 bus master: requests the bus, performs single-byte peek/poke cycles, then hands the bus back.
module z80_bus_master
  import z80_bus_pkg::*;
#(
  parameter int ACK_TIMEOUT = 4095,
  parameter int SETUP_CYC   = 2,
  parameter int STROBE_CYC  = 4,
  parameter int HOLD_CYC    = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [15:0] cmd_addr,
  input  logic [7:0]  cmd_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_data,
  output logic        rsp_err,
  output logic        owned,
  output logic        busrq_n,
  input  logic        busak_n,
  output logic        bus_oe,
  output logic        data_oe,
  output logic [15:0] addr,
  output logic [7:0]  dout,
  input  logic [7:0]  din,
  output logic        mreq_n,
  output logic        rd_n,
  output logic        wr_n
);

  localparam int TMAX = max_of(max_of(ACK_TIMEOUT, SETUP_CYC), max_of(STROBE_CYC, HOLD_CYC));
  localparam int TW   = $clog2(TMAX + 1);

  bus_state_e    state_q, state_d;
  cmd_op_e       op_q, op_d;
  logic [TW-1:0] timer_q, timer_d, timer_inc;
  logic [7:0]    rd_byte_q, rd_byte_d;
  logic          ak_s;
  logic          cmd_fire;
  logic          in_owned_phase;

  logic          busrq_n_d, mreq_n_d, rd_n_d, wr_n_d, bus_oe_d, data_oe_d, owned_d;
  logic          rsp_valid_d, rsp_err_d, cmd_ready_d;
  logic [15:0]   addr_d;
  logic [7:0]    dout_d, rsp_data_d;

  sync2 u_busak_sync (
    .clock (clock),
    .reset (reset),
    .d     (busak_n),
    .q     (ak_s)
  );

  assign cmd_fire       = cmd_valid & cmd_ready;
  assign timer_inc      = (timer_q == TW'(TMAX)) ? timer_q : timer_q + TW'(1);
  assign in_owned_phase = (state_q == ST_OWNED) || (state_q == ST_SETUP) ||
                          (state_q == ST_STROBE) || (state_q == ST_HOLD);

  // Next-state and next-output logic; losing the acknowledge while holding the bus overrides everything.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    timer_d     = timer_q;
    rd_byte_d   = rd_byte_q;
    busrq_n_d   = busrq_n;
    mreq_n_d    = mreq_n;
    rd_n_d      = rd_n;
    wr_n_d      = wr_n;
    bus_oe_d    = bus_oe;
    data_oe_d   = data_oe;
    owned_d     = owned;
    addr_d      = addr;
    dout_d      = dout;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data;
    rsp_err_d   = rsp_err;

    case (state_q)
      ST_IDLE: begin
        if (cmd_fire) begin
          if (cmd_op_e'(cmd_op) == OP_HALT) begin
            state_d = ST_REQ;
          end else begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_data_d  = 8'h00;
          end
        end
      end
      ST_REQ: begin
        busrq_n_d = 1'b0;
        timer_d   = '0;
        state_d   = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        if (!ak_s) begin
          owned_d     = 1'b1;
          bus_oe_d    = 1'b1;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_data_d  = 8'h00;
          state_d     = ST_OWNED;
        end else if (timer_q >= TW'(ACK_TIMEOUT - 1)) begin
          busrq_n_d   = 1'b1;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_data_d  = 8'h00;
          state_d     = ST_IDLE;
        end else begin
          timer_d = timer_inc;
        end
      end
      ST_OWNED: begin
        if (cmd_fire) begin
          case (cmd_op_e'(cmd_op))
            OP_HALT: begin
              rsp_valid_d = 1'b1;
              rsp_err_d   = 1'b0;
              rsp_data_d  = 8'h00;
            end
            OP_RELEASE: begin
              bus_oe_d  = 1'b0;
              data_oe_d = 1'b0;
              owned_d   = 1'b0;
              busrq_n_d = 1'b1;
              state_d   = ST_REL_WAIT;
            end
            OP_READ: begin
              op_d    = OP_READ;
              addr_d  = cmd_addr;
              timer_d = '0;
              state_d = ST_SETUP;
            end
            default: begin
              op_d      = OP_WRITE;
              addr_d    = cmd_addr;
              dout_d    = cmd_wdata;
              data_oe_d = 1'b1;
              timer_d   = '0;
              state_d   = ST_SETUP;
            end
          endcase
        end
      end
      ST_SETUP: begin
        if (timer_q >= TW'(SETUP_CYC - 1)) begin
          timer_d  = '0;
          mreq_n_d = 1'b0;
          if (op_q == OP_READ) rd_n_d = 1'b0;
          else                 wr_n_d = 1'b0;
          state_d  = ST_STROBE;
        end else begin
          timer_d = timer_inc;
        end
      end
      ST_STROBE: begin
        if (timer_q >= TW'(STROBE_CYC - 1)) begin
          timer_d  = '0;
          mreq_n_d = 1'b1;
          rd_n_d   = 1'b1;
          wr_n_d   = 1'b1;
          if (op_q == OP_READ) rd_byte_d = din;
          state_d  = ST_HOLD;
        end else begin
          timer_d = timer_inc;
        end
      end
      ST_HOLD: begin
        if (timer_q >= TW'(HOLD_CYC - 1)) begin
          timer_d     = '0;
          data_oe_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_data_d  = (op_q == OP_READ) ? rd_byte_q : 8'h00;
          state_d     = ST_OWNED;
        end else begin
          timer_d = timer_inc;
        end
      end
      ST_REL_WAIT: begin
        if (ak_s) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_data_d  = 8'h00;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (ak_s && in_owned_phase) begin
      mreq_n_d    = 1'b1;
      rd_n_d      = 1'b1;
      wr_n_d      = 1'b1;
      bus_oe_d    = 1'b0;
      data_oe_d   = 1'b0;
      owned_d     = 1'b0;
      busrq_n_d   = 1'b1;
      rsp_valid_d = 1'b1;
      rsp_err_d   = 1'b1;
      rsp_data_d  = 8'h00;
      timer_d     = '0;
      state_d     = ST_IDLE;
    end
  end

  assign cmd_ready_d = (state_d == ST_IDLE) || (state_d == ST_OWNED);

  // Register state, timer and every bus/response output so the pins are glitch-free.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_HALT;
      timer_q   <= '0;
      rd_byte_q <= 8'h00;
      busrq_n   <= 1'b1;
      mreq_n    <= 1'b1;
      rd_n      <= 1'b1;
      wr_n      <= 1'b1;
      bus_oe    <= 1'b0;
      data_oe   <= 1'b0;
      owned     <= 1'b0;
      addr      <= 16'h0000;
      dout      <= 8'h00;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= 8'h00;
      rsp_err   <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      timer_q   <= timer_d;
      rd_byte_q <= rd_byte_d;
      busrq_n   <= busrq_n_d;
      mreq_n    <= mreq_n_d;
      rd_n      <= rd_n_d;
      wr_n      <= wr_n_d;
      bus_oe    <= bus_oe_d;
      data_oe   <= data_oe_d;
      owned     <= owned_d;
      addr      <= addr_d;
      dout      <= dout_d;
      cmd_ready <= cmd_ready_d;
      rsp_valid <= rsp_valid_d;
      rsp_data  <= rsp_data_d;
      rsp_err   <= rsp_err_d;
    end
  end

endmodule

// File: doc/z80_bus_master.md
Name: z80_bus_master

Overview:
- Sequences the Z80 external bus on behalf of the serial command line.
- Requests the bus via BUSRQ_n and waits for BUSAK_n.
- Once the bus is owned, performs single-byte memory read/write cycles (peek/poke of ZX81 RAM/ROM), then releases the bus back to the CPU on command.
- Sits between the command-line parser (command/response handshake) and the Z80 bus pins / tri-state buffers.

Parameters:
- ACK_TIMEOUT, 4095, clocks to wait for busak_n low before aborting the request.
- SETUP_CYC, 2, clocks address/data are stable before the strobe asserts (min 1).
- STROBE_CYC, 4, clocks mreq_n plus rd_n/wr_n stay low (min 1).
- HOLD_CYC, 1, clocks address/data are held after the strobe deasserts (min 1).

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  block accepts command this cycle
- cmd_op  in  2  0=HALT, 1=RELEASE, 2=READ, 3=WRITE
- cmd_addr  in  16  memory address (READ/WRITE)
- cmd_wdata  in  8  write byte (WRITE)
- rsp_valid  out  1  one-cycle pulse, command finished
- rsp_data  out  8  read byte (valid with rsp_valid for READ, else 0)
- rsp_err  out  1  with rsp_valid: command failed
- owned  out  1  bus currently granted to this block
- busrq_n  out  1  Z80 bus request
- busak_n  in  1  Z80 bus acknowledge (asynchronous; 2-flop synchronised internally)
- bus_oe  out  1  enable address/control drivers
- data_oe  out  1  enable data-bus driver (WRITE only)
- addr  out  16  address bus
- dout  out  8  data bus out
- din  in  8  data bus in
- mreq_n, rd_n, wr_n  out  1 each  memory strobes

Behaviour:
- Reset (async, any state): busrq_n=1, mreq_n=rd_n=wr_n=1, bus_oe=data_oe=0, addr=0, dout=0, owned=0, cmd_ready=0, rsp_valid=0, rsp_data=0, rsp_err=0; state=IDLE; timers and synchroniser cleared.
- cmd_ready=1 only in IDLE and OWNED. A command is accepted when cmd_valid & cmd_ready; cmd_addr/cmd_wdata are latched on acceptance.
- States and transitions:
  - IDLE: HALT -> REQ. READ/WRITE/RELEASE -> immediate rsp_valid with rsp_err=1, stay in IDLE (RELEASE while idle also errors).
  - REQ: busrq_n<=0, timer cleared -> WAIT_ACK.
  - WAIT_ACK: synchronised busak_n==0 -> owned<=1, bus_oe<=1, rsp_valid(err=0) -> OWNED. Timer reaching ACK_TIMEOUT -> busrq_n<=1, rsp_err=1 -> IDLE.
  - OWNED: READ/WRITE -> SETUP with addr driven; WRITE also sets dout and data_oe=1. HALT -> rsp ok, stay. RELEASE -> bus_oe<=0, data_oe<=0, owned<=0, busrq_n<=1 -> REL_WAIT.
  - SETUP: hold for SETUP_CYC clocks -> STROBE (mreq_n=0, plus rd_n=0 for READ or wr_n=0 for WRITE).
  - STROBE: hold for STROBE_CYC clocks; on the final clock din is sampled into rsp_data (READ); strobes deassert -> HOLD.
  - HOLD: HOLD_CYC clocks, then data_oe<=0, rsp_valid pulse -> OWNED.
  - REL_WAIT: synchronised busak_n==1 -> rsp_valid(err=0) -> IDLE. No timeout applies.
- Drive rules: bus_oe is never high unless owned=1. Strobes and data_oe are never low/high while bus_oe=0. rd_n and wr_n are never low simultaneously.
- busak_n deasserting while OWNED or in any cycle state is a protocol error: strobes go high at once, drivers are disabled, owned=0, busrq_n=1. If a command is in flight, rsp_err=1; otherwise an unsolicited rsp_valid with rsp_err=1 is issued. -> IDLE.
- Latencies:
  - READ/WRITE acceptance to rsp_valid = 1 + SETUP_CYC + STROBE_CYC + HOLD_CYC clocks (defaults: 8).
  - HALT response arrives 2 sync clocks after busak_n falls.
- rsp_valid is a single-cycle pulse; the parser must accept it, as there is no backpressure. rsp_data holds its value until the next response.
- Timers are wide enough for the largest parameter. Counters saturate and never wrap.

Decomposition:
- Shared package z80_bus_pkg: cmd_op encodings (OP_HALT, OP_RELEASE, OP_READ, OP_WRITE) and state encodings for the sequencer, reusable by the cmdline parser.
- Natural sub-module: sync2, the two-flop synchroniser for busak_n, reset to 1.

Test Plan:
- HALT with busak_n falling 10 clocks after busrq_n -> rsp_valid, err=0, owned=1, bus_oe=1.
- Owned, WRITE addr=0x4000, data=0xA5 -> addr=0x4000, dout=0xA5, data_oe=1; wr_n low for 4 clocks after 2 setup clocks; rd_n stays 1; rsp after 8 clocks.
- Owned, READ addr=0x4000, memory model returns 0xA5 -> rsp_data=0xA5, err=0; wr_n stays 1; data_oe stays 0.
- HALT with busak_n held high, ACK_TIMEOUT=16 -> rsp_err=1 after 16 wait clocks, busrq_n returns to 1, back in IDLE.
- READ in IDLE -> immediate rsp_err=1, no strobe toggles. RELEASE while owned -> busrq_n=1, rsp after busak_n rises, owned=0.
- reset asserted mid-STROBE, and separately busak_n rising mid-STROBE -> all strobes high and drivers off immediately; the second case gives rsp_err=1.
